// File: rtl/ttm4_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : ttm4_prog_loader_pkg
// Brief  : Shared types and widths for the TTM4 program loader.
// Rev    : 1.0
// ============================================================================
package ttm4_prog_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 15;

    localparam int OP_MSB = 14;
    localparam int OP_LSB = 10;
    localparam int SR_MSB = 9;
    localparam int SR_LSB = 7;
    localparam int LR_MSB = 6;
    localparam int LR_LSB = 4;
    localparam int IM_MSB = 3;
    localparam int IM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT  = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_WR   = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    function automatic logic [INSTR_W-1:0] pack_instr(input logic [6:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttm4_prog_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module : ttm4_prog_loader_timeout
// Brief  : Byte-gap watchdog; fires on the LIMIT-th consecutive idle cycle.
// Rev    : 1.0
// ============================================================================
module ttm4_prog_loader_timeout #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    assign expire = run && (r_count == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!run || expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ttm4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : ttm4_prog_loader
// Brief  : Byte-stream boot loader writing 15-bit words into program memory.
// Rev    : 1.0
// ============================================================================
module ttm4_prog_loader
    import ttm4_prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000,
    parameter bit         BOOT_HOLD   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_add,
    output logic [INSTR_W-1:0] mem_data,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t          r_state;
    logic [ADDR_W:0] r_words_left;
    logic [7:0]      r_csum;
    logic [7:0]      r_lo;

    logic w_accept;
    logic w_wd_run;
    logic w_expire;

    assign w_accept = in_valid && in_ready;
    assign w_wd_run = (r_state == ST_CNT || r_state == ST_LO ||
                       r_state == ST_HI  || r_state == ST_CHK) && !w_accept;

    ttm4_prog_loader_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (w_wd_run),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_csum       <= '0;
            r_lo         <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_add      <= '0;
            mem_data     <= '0;
            cpu_rst      <= BOOT_HOLD;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (w_accept && in_data == SYNC_BYTE) begin
                        r_state <= ST_CNT;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                ST_CNT: begin
                    if (w_accept) begin
                        // A zero count encodes a full 256-word image
                        r_words_left <= (in_data == 8'h00) ? 9'h100 : {1'b0, in_data};
                        mem_add      <= '0;
                        r_csum       <= '0;
                        r_state      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_lo    <= in_data;
                        r_csum  <= r_csum + in_data;
                        r_state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        mem_data <= pack_instr(in_data[6:0], r_lo);
                        r_csum   <= r_csum + in_data;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                        r_state  <= ST_WR;
                    end
                end
                ST_WR: begin
                    in_ready     <= 1'b1;
                    mem_add      <= mem_add + 8'd1;
                    r_words_left <= r_words_left - 9'd1;
                    r_state      <= (r_words_left == 9'd1) ? ST_CHK : ST_LO;
                end
                ST_CHK: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Watchdog abort leaves CPU held; partial memory contents are harmless
            if (w_expire) begin
                err     <= 1'b1;
                busy    <= 1'b0;
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ttm4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_ttm4_prog_loader
// Brief  : Scoreboard bench for the TTM4 program loader.
// Rev    : 1.0
// ============================================================================
module tb_ttm4_prog_loader;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_add;
    logic [14:0] mem_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    ttm4_prog_loader #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO),
        .BOOT_HOLD   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_add  (mem_add),
        .mem_data (mem_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [14:0] d;
    } wr_t;

    wr_t        sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         wr_count = 0;
    logic [7:0] m_csum;
    logic [7:0] m_addr;
    logic [7:0] m_lo;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write monitor: every strobe must match the oldest pending expected word
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_t e;
            wr_count++;
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 32'(mem_add), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_eq("wr_addr", 32'(mem_add), 32'(e.a));
                check_eq("wr_data", 32'(mem_data), 32'(e.d));
            end
        end
    end

    // kind: 0 = framing byte, 1 = LO, 2 = HI
    task automatic send_byte(input logic [7:0] b, input int kind);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", 32'(in_ready), 32'd1);
        if (kind == 1) begin
            m_lo   = b;
            m_csum = m_csum + b;
        end else if (kind == 2) begin
            sb.push_back('{a: m_addr, d: {b[6:0], m_lo}});
            m_addr = m_addr + 8'd1;
            m_csum = m_csum + b;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (kind == 2) begin
            check_eq("we_latency", 32'(mem_we), 32'd1);
            check_eq("ready_in_wr", 32'(in_ready), 32'd0);
        end
    endtask

    task automatic start_image(input logic [7:0] n);
        send_byte(8'hA5, 0);
        send_byte(n, 0);
        m_csum = 8'h00;
        m_addr = 8'h00;
    endtask

    task automatic send_t1_words;
        send_byte(8'h34, 1);
        send_byte(8'h12, 2);
        send_byte(8'h78, 1);
        send_byte(8'h56, 2);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic b, input logic c);
        check_eq({tag, "_done"}, 32'(done), 32'(d));
        check_eq({tag, "_err"}, 32'(err), 32'(e));
        check_eq({tag, "_busy"}, 32'(busy), 32'(b));
        check_eq({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_add"}, 32'(mem_add), 32'd0);
        check_eq({tag, "_data"}, 32'(mem_data), 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int wr0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_csum   = 8'h00;
        m_addr   = 8'h00;
        m_lo     = 8'h00;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", 32'(in_ready), 32'd1);

        // T1: good two-word image
        start_image(8'h02);
        send_t1_words();
        check_status("t1_mid", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(m_csum, 0);
        check_status("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t1_add", 32'(mem_add), 32'd2);
        check_eq("t1_sb", 32'(sb.size()), 32'd0);

        // T2: bad checksum
        start_image(8'h02);
        send_t1_words();
        send_byte(m_csum + 8'd1, 0);
        check_status("t2", 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t2_sb", 32'(sb.size()), 32'd0);

        // T3: stall in HI until the watchdog fires
        wr0 = wr_count;
        start_image(8'h01);
        send_byte(8'hFF, 1);
        repeat (TO - 1) @(posedge clk);
        #1;
        check_status("t3_pre", 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_status("t3", 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t3_writes", 32'(wr_count - wr0), 32'd0);

        // T4: full 256-word image, random HI bit 7
        wr0 = wr_count;
        start_image(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1);
            send_byte(8'($urandom_range(0, 255)), 2);
        end
        send_byte(m_csum, 0);
        check_status("t4", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t4_add_wrap", 32'(mem_add), 32'd0);
        check_eq("t4_writes", 32'(wr_count - wr0), 32'd256);
        check_eq("t4_sb", 32'(sb.size()), 32'd0);

        // T5: junk byte dropped, sync re-arms CPU reset
        send_byte(8'h00, 0);
        check_status("t5_drop", 1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 0);
        check_status("t5_sync", 1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h02, 0);
        m_csum = 8'h00;
        m_addr = 8'h00;
        send_t1_words();
        send_byte(m_csum, 0);
        check_status("t5", 1'b1, 1'b0, 1'b0, 1'b0);

        // T6: reset mid-image then a clean reload
        start_image(8'h02);
        send_byte(8'h34, 1);
        send_byte(8'h12, 2);
        send_byte(8'h78, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start_image(8'h02);
        send_t1_words();
        send_byte(m_csum, 0);
        check_status("t6", 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t6_sb", 32'(sb.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
